// File: rtl/mult_shift_add_8.sv
// Sequential 8x8 unsigned shift-add multiplier with a 16-bit registered product.
// One 8-bit ripple-carry adder is reused for every iteration.

module rca_8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

module mult_shift_add_8 (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] Product,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  m;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic [3:0]  cnt;

  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        cout;
  logic [15:0] shifted;

  assign addend = lo[0] ? m : '0;

  rca_8 u_add (
    .x    (hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry-out re-enters as the new MSB of the accumulator on the right shift.
  assign shifted = {cout, sum, lo[7:1]};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      Product <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            m     <= A;
            hi    <= '0;
            lo    <= B;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          hi  <= shifted[15:8];
          lo  <= shifted[7:0];
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            Product <= shifted;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_shift_add_8.sv
// Directed bench for mult_shift_add_8: latency, carry path, ignored Start,
// back-to-back operation and asynchronous reset mid-operation.

module tb_mult_shift_add_8;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] Product;
  logic        Busy;
  logic        Done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mult_shift_add_8 dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Product (Product),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an operation and check the full 9-edge timeline; ends just after edge 8.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] prev, input logic [15:0] exp);
    @(negedge Clock);
    Start = 1'b1; A = a; B = b;
    @(negedge Clock);
    Start = 1'b0; A = 8'h00; B = 8'h00;
    check("busy_e0", {15'd0, Busy}, 16'd1);
    check("done_e0", {15'd0, Done}, 16'd0);
    for (int i = 1; i < 8; i++) begin
      @(negedge Clock);
      check("busy_run", {15'd0, Busy}, 16'd1);
      check("done_run", {15'd0, Done}, 16'd0);
      check("prod_hold", Product, prev);
    end
    @(negedge Clock);
    check("done_e8", {15'd0, Done}, 16'd1);
    check("busy_e8", {15'd0, Busy}, 16'd0);
    check("product", Product, exp);
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; A = 8'h00; B = 8'h00;
    #1;
    check("rst_product", Product, 16'h0000);
    check("rst_busy", {15'd0, Busy}, 16'd0);
    check("rst_done", {15'd0, Done}, 16'd0);
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;

    // Basic
    run_op(8'h0D, 8'h0B, 16'h0000, 16'h008F);
    @(negedge Clock);
    check("done_e9", {15'd0, Done}, 16'd0);
    check("busy_e9", {15'd0, Busy}, 16'd0);
    check("prod_keep", Product, 16'h008F);

    // Carry path, zero and identity operands
    run_op(8'hFF, 8'hFF, 16'h008F, 16'hFE01);
    run_op(8'h00, 8'hFF, 16'hFE01, 16'h0000);
    run_op(8'h80, 8'h01, 16'h0000, 16'h0080);
    @(negedge Clock);

    // Start held through RUN with different operands is ignored
    Start = 1'b1; A = 8'h07; B = 8'h09;
    @(negedge Clock);
    A = 8'h12; B = 8'h34;
    for (int i = 1; i < 8; i++) begin
      @(negedge Clock);
      check("ign_busy", {15'd0, Busy}, 16'd1);
    end
    @(negedge Clock);
    Start = 1'b0;
    check("ign_done", {15'd0, Done}, 16'd1);
    check("ign_product", Product, 16'h003F);
    @(negedge Clock);
    check("ign_done_e9", {15'd0, Done}, 16'd0);
    @(negedge Clock);
    check("ign_done_e10", {15'd0, Done}, 16'd0);
    check("ign_busy_e10", {15'd0, Busy}, 16'd0);

    // Back-to-back: second Start on the Done cycle
    run_op(8'h03, 8'h05, 16'h003F, 16'h000F);
    Start = 1'b1; A = 8'h10; B = 8'h10;
    @(negedge Clock);
    Start = 1'b0; A = 8'h00; B = 8'h00;
    check("b2b_busy_e9", {15'd0, Busy}, 16'd1);
    check("b2b_done_e9", {15'd0, Done}, 16'd0);
    for (int i = 10; i < 17; i++) begin
      @(negedge Clock);
      check("b2b_busy", {15'd0, Busy}, 16'd1);
      check("b2b_hold", Product, 16'h000F);
    end
    @(negedge Clock);
    check("b2b_done_e17", {15'd0, Done}, 16'd1);
    check("b2b_product", Product, 16'h0100);
    @(negedge Clock);

    // Reset during iteration 4
    Start = 1'b1; A = 8'hAA; B = 8'h55;
    @(negedge Clock);
    Start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge Clock);
    check("mid_busy_pre", {15'd0, Busy}, 16'd1);
    Resetn = 1'b0;
    #1;
    check("mid_product", Product, 16'h0000);
    check("mid_busy", {15'd0, Busy}, 16'd0);
    check("mid_done", {15'd0, Done}, 16'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("post_rst_done", {15'd0, Done}, 16'd0);
      check("post_rst_busy", {15'd0, Busy}, 16'd0);
    end
    run_op(8'hAA, 8'h55, 16'h0000, 16'h3872);
    @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
